load_buffer: RTL and testbench

- Holds issued LOAD instructions until their base operand is available and their address is computed.
- Each cycle, exposes every entry's ROB index and effective address to the reorder buffer for store-conflict checks.
- Accepts the ROB's per-entry can_load verdict, performs one fixed-latency data-memory read at a time, extracts and extends the loaded value, and presents it as a CDB result.
- Sits between the issue stage and the ROB/CDB.

---
 rtl/load_buffer_if.sv | 63 ++++++
 rtl/load_buffer.sv | 233 +++++++++++++++++++++++
 tb/tb_load_buffer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/load_buffer_if.sv
// Load buffer bus interface: issue, CDB snoop, ROB conflict check, data-memory
// read and CDB result signals grouped in one bundle.
//   slave  : the load buffer side (consumes issue/CDB/memory, drives results)
//   master : the environment side (issue stage, ROB, memory, CDB arbiter)
// Optional macro LOAD_BUFFER_PERF_EN adds the performance counter outputs.
interface load_buffer_if #(
  parameter int unsigned LOAD_BUFFER_DEPTH = 3,
  parameter int unsigned ROB_SIZE          = 8
) ();
  localparam int unsigned ROB_W = $clog2(ROB_SIZE);

  logic                                    valid_in;
  logic [ROB_W-1:0]                        rob_ix_in;
  logic [31:0]                             base_value_in;
  logic                                    base_ready_in;
  logic [ROB_W-1:0]                        base_tag_in;
  logic [31:0]                             offset_in;
  logic [2:0]                              funct3_in;
  logic                                    cdb_valid_in;
  logic [ROB_W-1:0]                        cdb_rob_ix_in;
  logic [31:0]                             cdb_value_in;
  logic                                    flush_in;
  logic [LOAD_BUFFER_DEPTH-1:0]            can_load_in;
  logic [31:0]                             mem_data_in;
  logic                                    result_grant_in;
  logic                                    ready_out;
  logic [LOAD_BUFFER_DEPTH-1:0][ROB_W-1:0] lb_rob_arr_ix_out;
  logic [LOAD_BUFFER_DEPTH-1:0][31:0]      lb_rob_arr_dest_out;
  logic [LOAD_BUFFER_DEPTH-1:0]            lb_valid_out;
  logic                                    mem_req_out;
  logic [31:0]                             mem_addr_out;
  logic                                    result_valid_out;
  logic [ROB_W-1:0]                        result_rob_ix_out;
  logic [31:0]                             result_value_out;
`ifdef LOAD_BUFFER_PERF_EN
  logic [31:0]                             perf_loads_out;
  logic [31:0]                             perf_conflict_stalls_out;
`endif

  modport slave (
    input  valid_in, rob_ix_in, base_value_in, base_ready_in, base_tag_in,
           offset_in, funct3_in, cdb_valid_in, cdb_rob_ix_in, cdb_value_in,
           flush_in, can_load_in, mem_data_in, result_grant_in,
`ifdef LOAD_BUFFER_PERF_EN
    output perf_loads_out, perf_conflict_stalls_out,
`endif
    output ready_out, lb_rob_arr_ix_out, lb_rob_arr_dest_out, lb_valid_out,
           mem_req_out, mem_addr_out, result_valid_out, result_rob_ix_out,
           result_value_out
  );

  modport master (
    output valid_in, rob_ix_in, base_value_in, base_ready_in, base_tag_in,
           offset_in, funct3_in, cdb_valid_in, cdb_rob_ix_in, cdb_value_in,
           flush_in, can_load_in, mem_data_in, result_grant_in,
`ifdef LOAD_BUFFER_PERF_EN
    input  perf_loads_out, perf_conflict_stalls_out,
`endif
    input  ready_out, lb_rob_arr_ix_out, lb_rob_arr_dest_out, lb_valid_out,
           mem_req_out, mem_addr_out, result_valid_out, result_rob_ix_out,
           result_value_out
  );
endinterface

// File: rtl/load_buffer.sv
// Load buffer: holds issued loads until their base operand arrives, exposes
// per-entry ROB index / effective address for store-conflict checks, and runs
// one fixed-latency data-memory read at a time, returning the extended value
// as a CDB result.
// Ports:
//   clk_in  - clock, rising edge
//   rst_in  - asynchronous active-high reset
//   lb      - load_buffer_if.slave (issue, CDB, ROB verdict, memory, result)
// Optional macro LOAD_BUFFER_PERF_EN adds perf_loads_out and
// perf_conflict_stalls_out counters (cleared by reset only).
module load_buffer #(
  parameter int unsigned LOAD_BUFFER_DEPTH = 3,
  parameter int unsigned ROB_SIZE          = 8,
  parameter int unsigned MEM_LATENCY       = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  load_buffer_if.slave  lb
);
  localparam int unsigned DEPTH = LOAD_BUFFER_DEPTH;
  localparam int unsigned ROB_W = $clog2(ROB_SIZE);
  localparam int unsigned IX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESULT} state_e;

  // Entry storage
  logic [DEPTH-1:0] valid_q, base_ready_q, in_flight_q;
  logic [ROB_W-1:0] rob_ix_q     [DEPTH];
  logic [ROB_W-1:0] base_tag_q   [DEPTH];
  logic [2:0]       funct3_q     [DEPTH];
  logic [31:0]      offset_q     [DEPTH];
  logic [31:0]      base_value_q [DEPTH];

  // Control / registered outputs
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IX_W-1:0]  issue_ix_q;
  logic             mem_req_q;
  logic [31:0]      mem_addr_q;
  logic             result_valid_q;
  logic [ROB_W-1:0] result_rob_ix_q;
  logic [31:0]      result_value_q;

  // Combinational helpers
  logic [31:0]      addr_c [DEPTH];
  logic [DEPTH-1:0] addr_ok_c, elig_c;
  logic             have_free_c, have_elig_c;
  logic [IX_W-1:0]  free_ix_c, elig_ix_c;
  logic             alloc_c, alloc_ready_c;
  logic [31:0]      alloc_value_c;
  logic [DEPTH-1:0][ROB_W-1:0] ix_arr_c;
  logic [DEPTH-1:0][31:0]      dest_arr_c;

  // Byte/half lane extraction with sign or zero extension
  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [1:0]  lane,
                                          input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Effective addresses, eligibility and lowest-index free/eligible picks;
  // scanning downward lets the lowest index overwrite the others.
  always_comb begin
    have_free_c = 1'b0;
    have_elig_c = 1'b0;
    free_ix_c   = '0;
    elig_ix_c   = '0;
    addr_ok_c   = '0;
    elig_c      = '0;
    ix_arr_c    = '0;
    dest_arr_c  = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      addr_c[i]    = base_value_q[i] + offset_q[i];
      addr_ok_c[i] = valid_q[i] & base_ready_q[i];
      elig_c[i]    = addr_ok_c[i] & lb.can_load_in[i] & ~in_flight_q[i];
      if (!valid_q[i]) begin
        have_free_c = 1'b1;
        free_ix_c   = IX_W'(i);
      end
      if (elig_c[i]) begin
        have_elig_c = 1'b1;
        elig_ix_c   = IX_W'(i);
      end
      if (valid_q[i]) begin
        ix_arr_c[i]   = rob_ix_q[i];
        dest_arr_c[i] = addr_c[i];
      end
    end
  end

  // Incoming load: base ready directly or forwarded from the CDB this cycle
  always_comb begin
    alloc_c       = lb.valid_in & have_free_c;
    alloc_ready_c = lb.base_ready_in |
                    (lb.cdb_valid_in && (lb.cdb_rob_ix_in == lb.base_tag_in));
    alloc_value_c = lb.base_ready_in ? lb.base_value_in : lb.cdb_value_in;
  end

  // Entry array, wakeup, allocation and the single-outstanding-load FSM
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q         <= '0;
      base_ready_q    <= '0;
      in_flight_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        rob_ix_q[i]     <= '0;
        base_tag_q[i]   <= '0;
        funct3_q[i]     <= '0;
        offset_q[i]     <= '0;
        base_value_q[i] <= '0;
      end
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      issue_ix_q      <= '0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
      result_valid_q  <= 1'b0;
      result_rob_ix_q <= '0;
      result_value_q  <= '0;
    end else if (lb.flush_in) begin
      valid_q        <= '0;
      in_flight_q    <= '0;
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      mem_req_q      <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      mem_req_q <= 1'b0;

      for (int i = 0; i < int'(DEPTH); i++) begin
        if (valid_q[i] && !base_ready_q[i] && lb.cdb_valid_in &&
            (lb.cdb_rob_ix_in == base_tag_q[i])) begin
          base_ready_q[i] <= 1'b1;
          base_value_q[i] <= lb.cdb_value_in;
        end
      end

      // Allocated slot is free now, so it never collides with the WAIT free
      if (alloc_c) begin
        valid_q[free_ix_c]      <= 1'b1;
        in_flight_q[free_ix_c]  <= 1'b0;
        rob_ix_q[free_ix_c]     <= lb.rob_ix_in;
        funct3_q[free_ix_c]     <= lb.funct3_in;
        offset_q[free_ix_c]     <= lb.offset_in;
        base_tag_q[free_ix_c]   <= lb.base_tag_in;
        base_ready_q[free_ix_c] <= alloc_ready_c;
        base_value_q[free_ix_c] <= alloc_value_c;
      end

      case (state_q)
        ST_IDLE: begin
          if (have_elig_c) begin
            mem_req_q              <= 1'b1;
            mem_addr_q             <= {addr_c[elig_ix_c][31:2], 2'b00};
            in_flight_q[elig_ix_c] <= 1'b1;
            issue_ix_q             <= elig_ix_c;
            cnt_q                  <= CNT_W'(MEM_LATENCY - 1);
            state_q                <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            result_valid_q          <= 1'b1;
            result_rob_ix_q         <= rob_ix_q[issue_ix_q];
            result_value_q          <= extract(lb.mem_data_in,
                                               addr_c[issue_ix_q][1:0],
                                               funct3_q[issue_ix_q]);
            valid_q[issue_ix_q]     <= 1'b0;
            in_flight_q[issue_ix_q] <= 1'b0;
            state_q                 <= ST_RESULT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESULT: begin
          if (lb.result_grant_in) begin
            result_valid_q <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef LOAD_BUFFER_PERF_EN
  logic [31:0] perf_loads_q, perf_stalls_q;

  // Issued reads and IDLE cycles blocked only by ROB conflict verdicts
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      perf_loads_q  <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (mem_req_q)
        perf_loads_q <= perf_loads_q + 32'd1;
      if ((state_q == ST_IDLE) && (|addr_ok_c) && !have_elig_c)
        perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign lb.perf_loads_out           = perf_loads_q;
  assign lb.perf_conflict_stalls_out = perf_stalls_q;
`endif

  assign lb.ready_out           = have_free_c;
  assign lb.lb_valid_out        = addr_ok_c;
  assign lb.lb_rob_arr_ix_out   = ix_arr_c;
  assign lb.lb_rob_arr_dest_out = dest_arr_c;
  assign lb.mem_req_out         = mem_req_q;
  assign lb.mem_addr_out        = mem_addr_q;
  assign lb.result_valid_out    = result_valid_q;
  assign lb.result_rob_ix_out   = result_rob_ix_q;
  assign lb.result_value_out    = result_value_q;
endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer: single loads, lane extraction, CDB wakeup,
// full buffer, conflict ordering, result back-pressure and flush.
module tb_load_buffer;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  always #5 clk_in = ~clk_in;

  load_buffer_if #(.LOAD_BUFFER_DEPTH(3), .ROB_SIZE(8)) lbi ();

  load_buffer #(.LOAD_BUFFER_DEPTH(3), .ROB_SIZE(8), .MEM_LATENCY(2)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .lb     (lbi)
  );

`ifdef LOAD_BUFFER_PERF_EN
  int req_seen = 0;
  always @(posedge clk_in) if (lbi.mem_req_out) req_seen++;
`endif

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] rob, input logic [31:0] base, input logic rdy,
                       input logic [2:0] tag, input logic [31:0] off, input logic [2:0] f3);
    lbi.rob_ix_in     = rob;
    lbi.base_value_in = base;
    lbi.base_ready_in = rdy;
    lbi.base_tag_in   = tag;
    lbi.offset_in     = off;
    lbi.funct3_in     = f3;
    lbi.valid_in      = 1'b1;
    tick();
    lbi.valid_in      = 1'b0;
    lbi.base_ready_in = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    bit seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (lbi.mem_req_out) seen = 1'b1;
    end
    chk({tag, "_req"}, 32'(seen), 32'd1);
    chk({tag, "_addr"}, lbi.mem_addr_out, exp_addr);
  endtask

  task automatic wait_res(input string tag, input logic [2:0] rob, input logic [31:0] val);
    bit seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (lbi.result_valid_out) seen = 1'b1;
    end
    chk({tag, "_rvalid"}, 32'(seen), 32'd1);
    chk({tag, "_rtag"}, 32'(lbi.result_rob_ix_out), 32'(rob));
    chk({tag, "_rval"}, lbi.result_value_out, val);
  endtask

  task automatic grant(input string tag);
    lbi.result_grant_in = 1'b1;
    tick();
    lbi.result_grant_in = 1'b0;
    chk({tag, "_drop"}, 32'(lbi.result_valid_out), 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] rob, input logic [31:0] base,
                         input logic [31:0] off, input logic [2:0] f3,
                         input logic [31:0] word, input logic [31:0] expv);
    logic [31:0] ea;
    ea = base + off;
    lbi.mem_data_in = word;
    issue(rob, base, 1'b1, 3'd0, off, f3);
    wait_req(tag, {ea[31:2], 2'b00});
    wait_res(tag, rob, expv);
    chk({tag, "_freed"}, 32'(lbi.lb_valid_out), 32'd0);
    grant(tag);
  endtask

  initial begin
    bit seen;
    lbi.valid_in = 0; lbi.rob_ix_in = 0; lbi.base_value_in = 0; lbi.base_ready_in = 0;
    lbi.base_tag_in = 0; lbi.offset_in = 0; lbi.funct3_in = 0; lbi.cdb_valid_in = 0;
    lbi.cdb_rob_ix_in = 0; lbi.cdb_value_in = 0; lbi.flush_in = 0; lbi.can_load_in = 3'b111;
    lbi.mem_data_in = 0; lbi.result_grant_in = 0;

    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(lbi.ready_out), 32'd1);
    chk("rst_lbvalid", 32'(lbi.lb_valid_out), 32'd0);
    chk("rst_req", 32'(lbi.mem_req_out), 32'd0);
    chk("rst_rvalid", 32'(lbi.result_valid_out), 32'd0);
    chk("rst_dest0", lbi.lb_rob_arr_dest_out[0], 32'd0);
    rst_in = 1'b0;
    tick();

    // LW base 0x100 + 8
    lbi.mem_data_in = 32'hDEADBEEF;
    issue(3'd2, 32'h100, 1'b1, 3'd0, 32'd8, 3'b010);
    chk("lw_lbvalid", 32'(lbi.lb_valid_out), 32'd1);
    chk("lw_dest", lbi.lb_rob_arr_dest_out[0], 32'h108);
    chk("lw_ix", 32'(lbi.lb_rob_arr_ix_out[0]), 32'd2);
    wait_req("lw", 32'h108);
    wait_res("lw", 3'd2, 32'hDEADBEEF);
    chk("lw_freed", 32'(lbi.lb_valid_out), 32'd0);
    chk("lw_ready", 32'(lbi.ready_out), 32'd1);
    grant("lw");

    // Lane extraction on word 0x80FF_0000
    do_load("lb3",  3'd1, 32'h100, 32'd3, 3'b000, 32'h80FF0000, 32'hFFFFFF80);
    do_load("lbu3", 3'd1, 32'h100, 32'd3, 3'b100, 32'h80FF0000, 32'h00000080);
    do_load("lh2",  3'd1, 32'h100, 32'd2, 3'b001, 32'h80FF0000, 32'hFFFF80FF);
    do_load("lhu2", 3'd1, 32'h100, 32'd2, 3'b101, 32'h80FF0000, 32'h000080FF);
    do_load("lb2",  3'd6, 32'h100, 32'd2, 3'b000, 32'h80FF0000, 32'hFFFFFFFF);
    do_load("lb0",  3'd7, 32'h100, 32'd0, 3'b000, 32'h80FF0000, 32'h00000000);

    // Base waits for tag 5, CDB arrives two cycles later
    lbi.mem_data_in = 32'h11223344;
    issue(3'd3, 32'd0, 1'b0, 3'd5, 32'h10, 3'b010);
    chk("wk_notyet", 32'(lbi.lb_valid_out), 32'd0);
    tick();
    chk("wk_notyet2", 32'(lbi.lb_valid_out), 32'd0);
    lbi.cdb_valid_in = 1'b1; lbi.cdb_rob_ix_in = 3'd5; lbi.cdb_value_in = 32'h200;
    tick();
    lbi.cdb_valid_in = 1'b0;
    chk("wk_lbvalid", 32'(lbi.lb_valid_out), 32'd1);
    chk("wk_dest", lbi.lb_rob_arr_dest_out[0], 32'h210);
    wait_req("wk", 32'h210);
    wait_res("wk", 3'd3, 32'h11223344);
    grant("wk");

    // CDB forwarding on the allocation cycle, negative offset
    lbi.cdb_valid_in = 1'b1; lbi.cdb_rob_ix_in = 3'd4; lbi.cdb_value_in = 32'h300;
    issue(3'd6, 32'd0, 1'b0, 3'd4, 32'hFFFFFFFC, 3'b010);
    lbi.cdb_valid_in = 1'b0;
    chk("fw_lbvalid", 32'(lbi.lb_valid_out), 32'd1);
    chk("fw_dest", lbi.lb_rob_arr_dest_out[0], 32'h2FC);
    wait_req("fw", 32'h2FC);
    wait_res("fw", 3'd6, 32'h11223344);
    grant("fw");

    // Fill all entries while the ROB blocks everything
    lbi.can_load_in = 3'b000;
    issue(3'd1, 32'h10, 1'b1, 3'd0, 32'd0, 3'b010);
    issue(3'd2, 32'h20, 1'b1, 3'd0, 32'd0, 3'b010);
    issue(3'd3, 32'h30, 1'b1, 3'd0, 32'd0, 3'b010);
    chk("full_ready", 32'(lbi.ready_out), 32'd0);
    chk("full_lbvalid", 32'(lbi.lb_valid_out), 32'd7);
    issue(3'd4, 32'h40, 1'b1, 3'd0, 32'd0, 3'b010);
    chk("full_ignore_ix", 32'(lbi.lb_rob_arr_ix_out), 32'h0D1);
    chk("full_ignore_dest2", lbi.lb_rob_arr_dest_out[2], 32'h30);
    chk("full_noreq", 32'(lbi.mem_req_out), 32'd0);

    // Only entry 1 cleared by the ROB
    lbi.mem_data_in = 32'hCAFEF00D;
    lbi.can_load_in = 3'b010;
    wait_req("c1", 32'h20);
    lbi.can_load_in = 3'b111;
    wait_res("c1", 3'd2, 32'hCAFEF00D);
    chk("c1_lbvalid", 32'(lbi.lb_valid_out), 32'd5);
    chk("c1_ready", 32'(lbi.ready_out), 32'd1);

    // Back-pressure: result holds, no new read
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("hold_rvalid", 32'(lbi.result_valid_out), 32'd1);
      chk("hold_rtag", 32'(lbi.result_rob_ix_out), 32'd2);
      chk("hold_rval", lbi.result_value_out, 32'hCAFEF00D);
      chk("hold_noreq", 32'(lbi.mem_req_out), 32'd0);
    end
    grant("c1");
    wait_req("c0", 32'h10);

    // Flush while the read is in flight
    lbi.flush_in = 1'b1;
    tick();
    lbi.flush_in = 1'b0;
    chk("fl_lbvalid", 32'(lbi.lb_valid_out), 32'd0);
    chk("fl_ready", 32'(lbi.ready_out), 32'd1);
    chk("fl_rvalid", 32'(lbi.result_valid_out), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (lbi.result_valid_out || lbi.mem_req_out) seen = 1'b1;
    end
    chk("fl_quiet", 32'(seen), 32'd0);

`ifdef LOAD_BUFFER_PERF_EN
    chk("perf_loads", lbi.perf_loads_out, 32'(req_seen));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
